// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction SRAM read port plus the fetch-to-decode
// valid/allowin handshake.
interface fetch_unit_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic        ds_allowin;
    logic [64:0] fs_to_ds_bus;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size,
        output inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
        input  ds_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size,
        input  inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
        output ds_allowin
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pipelined SRAM reads feeding an in-order
// instruction FIFO, with branch/exception redirect and stale-data discard.
module fetch_unit #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         br_stall,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    input  logic         expt_clear,
    input  logic [31:0]  expt_refresh_pc,
    fetch_unit_if.master bus
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [2:0]    outstanding;
    logic [2:0]    discard;
    logic [2:0]    out_next;
    logic          halt;
    logic          hold;

    logic [64:0]   fifo [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   pcq [4];
    logic [1:0]    pq_rd;
    logic [1:0]    pq_wr;

    logic          redirect;
    logic [31:0]   new_pc;
    logic          aligned;
    logic          full;
    logic          can_issue;
    logic          req;
    logic          issue;
    logic          data_fire;
    logic          keep;
    logic          adef_push;
    logic          push;
    logic          pop;
    logic          valid;
    logic [64:0]   push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == 32'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect  = br_taken | expt_clear;
    assign new_pc    = expt_clear ? expt_refresh_pc : br_target;
    assign aligned   = (fetch_pc[1:0] == 2'b00);
    assign full      = (32'(count) == 32'(BUF_DEPTH));

    assign can_issue = ~br_stall & ~halt & aligned
                     & (outstanding < 3'(MAX_OUTSTANDING))
                     & ((32'(count) + 32'(outstanding)) < 32'(BUF_DEPTH));
    // Once offered, a request stays up until taken or redirected.
    assign req       = ~reset & (hold | can_issue);
    assign issue     = req & bus.inst_sram_addr_ok;

    assign data_fire = bus.inst_sram_data_ok & (outstanding != 3'd0);
    assign keep      = data_fire & (discard == 3'd0) & ~redirect;
    assign adef_push = ~aligned & ~halt & ~redirect & ~full
                     & (outstanding == 3'd0) & (discard == 3'd0);
    assign push      = keep | adef_push;
    assign push_data = adef_push ? {1'b1, fetch_pc, 32'h0}
                                 : {1'b0, pcq[pq_rd], bus.inst_sram_rdata};

    assign valid     = (count != '0) & ~expt_clear;
    assign pop       = valid & bus.ds_allowin;
    assign out_next  = outstanding + {2'b00, issue} - {2'b00, data_fire};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 3'd0;
            discard     <= 3'd0;
            halt        <= 1'b0;
            hold        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pq_rd       <= 2'd0;
            pq_wr       <= 2'd0;
        end else begin
            outstanding <= out_next;
            if (issue)
                pq_wr <= pq_wr + 2'd1;
            if (data_fire)
                pq_rd <= pq_rd + 2'd1;
            if (redirect) begin
                // Every read still in flight after this edge is stale.
                fetch_pc <= new_pc;
                discard  <= out_next;
                halt     <= 1'b0;
                hold     <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (data_fire && discard != 3'd0)
                    discard <= discard - 3'd1;
                if (adef_push)
                    halt <= 1'b1;
                hold <= req & ~bus.inst_sram_addr_ok;
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= push_data;
        if (issue)
            pcq[pq_wr] <= fetch_pc;
    end

    assign bus.inst_sram_req   = req;
    assign bus.inst_sram_addr  = fetch_pc;
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'b10;
    assign bus.inst_sram_wstrb = 4'h0;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.fs_to_ds_valid  = valid;
    assign bus.fs_to_ds_bus    = (count != '0) ? fifo[rd_ptr] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, sequential-stream reference
// and directed redirect/stall/reset scenarios plus a randomized soak.
module tb_fetch_unit;
    localparam int          MAXO  = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic        expt_clear = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] expt_refresh_pc = 32'h0;

    fetch_unit_if bus();

    fetch_unit #(
        .MAX_OUTSTANDING(MAXO),
        .BUF_DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .br_stall(br_stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .expt_clear(expt_clear),
        .expt_refresh_pc(expt_refresh_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int aok_pct = 100;
    int dok_pct = 100;
    int allow_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    bit stale_inject = 1'b0;

    mreq_t       memq [$];
    int          last_due = 0;
    logic [31:0] acc_log [$];
    logic [64:0] del_log [$];

    logic [31:0] exp_issue;
    logic [31:0] exp_deliv;
    bit          deliv_done;
    int          tb_out;
    int          stale;
    int          tb_fifo;
    int          n_drop;
    bit          hold_prev;
    logic [31:0] prev_addr;

    task automatic check(input string name, input logic [64:0] act,
                         input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 32'hffff_ffff;
    endfunction

    function automatic logic [64:0] del_at(input int i);
        return (del_log.size() > i) ? del_log[i] : '1;
    endfunction

    task automatic model_clear();
        memq.delete();
        last_due   = 0;
        exp_issue  = RPC;
        exp_deliv  = RPC;
        deliv_done = 1'b0;
        tb_out     = 0;
        stale      = 0;
        tb_fifo    = 0;
        hold_prev  = 1'b0;
        prev_addr  = 32'h0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        br_taken = 1'b0;
        expt_clear = 1'b0;
        bus.inst_sram_addr_ok = 1'b1;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata = 32'h0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset_req", 65'(bus.inst_sram_req), 65'h0);
            check("reset_valid", 65'(bus.fs_to_ds_valid), 65'h0);
            check("reset_bus", bus.fs_to_ds_bus, 65'h0);
        end
        model_clear();
        reset = 1'b0;
    endtask

    task automatic step();
        logic        req;
        logic        aok;
        logic        dok;
        logic        val;
        logic        alw;
        logic        redir;
        logic        dfire;
        logic [31:0] addr;
        logic [31:0] tgt;
        logic [64:0] bb;
        int          d;

        @(negedge clk);
        aok = ($urandom_range(99) < aok_pct);
        dok = 1'b0;
        bus.inst_sram_rdata = 32'h0;
        if (stale_inject) begin
            dok = 1'b1;
            bus.inst_sram_rdata = 32'hdeadbeef;
        end else if (memq.size() > 0 && int'(memq[0].due) <= cyc
                     && $urandom_range(99) < dok_pct) begin
            dok = 1'b1;
            bus.inst_sram_rdata = ~memq[0].addr;
        end
        bus.inst_sram_addr_ok = aok;
        bus.inst_sram_data_ok = dok;
        bus.ds_allowin = ($urandom_range(99) < allow_pct);
        #1;
        req   = bus.inst_sram_req;
        addr  = bus.inst_sram_addr;
        val   = bus.fs_to_ds_valid;
        bb    = bus.fs_to_ds_bus;
        alw   = bus.ds_allowin;
        redir = br_taken | expt_clear;
        tgt   = expt_clear ? expt_refresh_pc : br_target;

        if (req)
            check("const_write_fields",
                  65'({bus.inst_sram_wr, bus.inst_sram_size,
                       bus.inst_sram_wstrb, bus.inst_sram_wdata}),
                  65'({1'b0, 2'b10, 4'h0, 32'h0}));
        if (hold_prev)
            check("req_held_stable", 65'({req, addr}), 65'({1'b1, prev_addr}));
        if (exp_issue[1:0] != 2'b00)
            check("misaligned_no_req", 65'(req), 65'h0);
        if (expt_clear)
            check("valid_during_flush", 65'(val), 65'h0);
        else if (tb_fifo > 0)
            check("valid_nonempty", 65'(val), 65'h1);
        else if (exp_deliv[1:0] == 2'b00)
            check("valid_empty", 65'(val), 65'h0);

        if (req && aok) begin
            check("issue_addr", 65'(addr), 65'(exp_issue));
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d < last_due)
                d = last_due;
            last_due = d;
            memq.push_back('{addr: addr, due: 32'(d)});
            acc_log.push_back(addr);
            exp_issue = exp_issue + 32'd4;
        end

        dfire = dok && (tb_out > 0);
        if (dok && !stale_inject && memq.size() > 0)
            void'(memq.pop_front());
        if (dfire) begin
            if (stale > 0 || redir) begin
                if (stale > 0)
                    stale--;
                n_drop++;
            end else begin
                tb_fifo++;
            end
        end
        tb_out = tb_out + ((req && aok) ? 1 : 0) - (dfire ? 1 : 0);

        if (val && alw) begin
            del_log.push_back(bb);
            if (deliv_done) begin
                check("delivery_after_adef", 65'(val & alw), 65'h0);
            end else if (exp_deliv[1:0] != 2'b00) begin
                check("adef_entry", bb, {1'b1, exp_deliv, 32'h0});
                deliv_done = 1'b1;
            end else begin
                check("deliver_seq", bb, {1'b0, exp_deliv, ~exp_deliv});
                exp_deliv = exp_deliv + 32'd4;
                tb_fifo--;
            end
        end

        if (redir) begin
            exp_issue  = tgt;
            exp_deliv  = tgt;
            deliv_done = 1'b0;
            tb_fifo    = 0;
            stale      = tb_out;
        end

        check("outstanding_bound", 65'(tb_out <= MAXO), 65'h1);
        check("occupancy_bound", 65'(tb_out + tb_fifo <= DEPTH), 65'h1);

        hold_prev = req & ~aok & ~redir;
        prev_addr = addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata = 32'h0;
        bus.ds_allowin = 1'b1;
        model_clear();
        n_drop = 0;
        do_reset(2);

        // Back-to-back fetch with single-cycle memory.
        acc_log.delete();
        del_log.delete();
        repeat (20) step();
        check("r026_accepts", 65'(acc_log.size()), 65'd20);
        check("r026_addr0", 65'(acc_at(0)), 65'h1c000000);
        check("r026_addr1", 65'(acc_at(1)), 65'h1c000004);
        check("r026_delivered", 65'(del_log.size()), 65'd18);
        check("r026_first_bus", del_at(0), {1'b0, 32'h1c000000, 32'he3ffffff});
        check("r026_last_pc", 65'(del_at(17)[63:32]), 65'h1c000044);

        // Decode stalled for 10 cycles.
        allow_pct = 0;
        acc_log.delete();
        repeat (10) step();
        check("r027_accepts", 65'(acc_log.size()), 65'd2);
        check("r027_req_off", 65'(bus.inst_sram_req), 65'h0);
        check("r027_valid_held", 65'(bus.fs_to_ds_valid), 65'h1);
        allow_pct = 100;
        del_log.delete();
        repeat (8) step();
        check("r027_resume_pc", 65'(del_at(0)[63:32]), 65'h1c000048);
        check("r027_resume_next", 65'(del_at(1)[63:32]), 65'h1c00004c);

        // Branch with two reads in flight.
        br_stall = 1'b1;
        repeat (8) step();
        br_stall = 1'b0;
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (tb_out < 2 && k < 20) begin
            step();
            k++;
        end
        check("r028_reach_two", 65'(k < 20), 65'h1);
        br_taken = 1'b1;
        br_target = 32'h1c000100;
        n_drop = 0;
        del_log.delete();
        step();
        br_taken = 1'b0;
        repeat (14) step();
        check("r028_dropped", 65'(n_drop), 65'd2);
        check("r028_first_bus", del_at(0), {1'b0, 32'h1c000100, 32'he3fffeff});
        lat_min = 1;
        lat_max = 1;

        // Exception flush wins over simultaneous branch.
        repeat (4) step();
        br_taken = 1'b1;
        expt_clear = 1'b1;
        br_target = 32'h1c000200;
        expt_refresh_pc = 32'h1c008000;
        step();
        br_taken = 1'b0;
        expt_clear = 1'b0;
        acc_log.delete();
        del_log.delete();
        repeat (6) step();
        check("r029_issue_addr", 65'(acc_at(0)), 65'h1c008000);
        check("r029_first_pc", 65'(del_at(0)[63:32]), 65'h1c008000);

        // Misaligned branch target.
        br_taken = 1'b1;
        br_target = 32'h1c000102;
        step();
        br_taken = 1'b0;
        acc_log.delete();
        del_log.delete();
        repeat (12) step();
        check("r030_no_issue", 65'(acc_log.size()), 65'd0);
        check("r030_one_entry", 65'(del_log.size()), 65'd1);
        check("r030_adef_bus", del_at(0), {1'b1, 32'h1c000102, 32'h0});
        expt_clear = 1'b1;
        expt_refresh_pc = 32'h1c000300;
        step();
        expt_clear = 1'b0;
        acc_log.delete();
        repeat (4) step();
        check("r030_restart_addr", 65'(acc_at(0)), 65'h1c000300);

        // Reset mid-transaction, then a stale return.
        lat_min = 3;
        lat_max = 3;
        repeat (3) step();
        do_reset(2);
        br_stall = 1'b1;
        stale_inject = 1'b1;
        step();
        stale_inject = 1'b0;
        repeat (2) step();
        check("r025_stale_ignored", 65'(bus.fs_to_ds_valid), 65'h0);
        br_stall = 1'b0;
        lat_min = 1;
        lat_max = 1;
        acc_log.delete();
        del_log.delete();
        repeat (6) step();
        check("r025_first_addr", 65'(acc_at(0)), 65'(RPC));
        check("r025_first_bus", del_at(0), {1'b0, RPC, ~RPC});

        // Randomized soak against the sequential reference.
        aok_pct = 60;
        dok_pct = 70;
        allow_pct = 70;
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            br_stall = ($urandom_range(99) < 10);
            br_taken = 1'b0;
            expt_clear = 1'b0;
            if ($urandom_range(99) < 3) begin
                br_taken = 1'b1;
                br_target = 32'h1c000000 + {22'h0, 8'($urandom_range(255)), 2'b00};
                if ($urandom_range(9) == 0)
                    br_target[1:0] = 2'b10;
            end
            if ($urandom_range(99) < 1) begin
                expt_clear = 1'b1;
                expt_refresh_pc = 32'h1c001000 + {24'h0, 6'($urandom_range(63)), 2'b00};
            end
            step();
        end
        br_stall = 1'b0;
        br_taken = 1'b0;
        expt_clear = 1'b1;
        expt_refresh_pc = 32'h1c002000;
        step();
        expt_clear = 1'b0;
        aok_pct = 100;
        dok_pct = 100;
        allow_pct = 100;
        lat_max = 1;
        del_log.delete();
        repeat (30) step();
        check("r031_drain_pc", 65'(del_at(0)[63:32]), 65'h1c002000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
